// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per clock; results land in HI/LO on the last iteration edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  // Two guard bits keep the Booth partial sum from overflowing when |b| = 2^(WIDTH-1).
  localparam int AW = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW+WIDTH-1:0] acc_q, acc_d;
  logic                qm1_q, qm1_d;
  logic [AW-1:0]       opnd_q, opnd_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [AW-1:0]       booth_sum;
  logic [AW+WIDTH-1:0] booth_acc;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH+1:0]    div_diff;
  logic [WIDTH:0]      rem_n;
  logic [WIDTH-1:0]    quo_n;
  logic [AW+WIDTH-1:0] div_acc;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth step: acc = {A, Q}; add/subtract M per {Q[0], q-1}, then arithmetic shift right.
  always_comb begin
    unique case ({acc_q[0], qm1_q})
      2'b01:   booth_sum = acc_q[AW+WIDTH-1:WIDTH] + opnd_q;
      2'b10:   booth_sum = acc_q[AW+WIDTH-1:WIDTH] - opnd_q;
      default: booth_sum = acc_q[AW+WIDTH-1:WIDTH];
    endcase
    booth_acc = {booth_sum[AW-1], booth_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring step: acc = {remainder, dividend shifting out / quotient shifting in}.
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - opnd_q;
    rem_n     = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
    quo_n     = {acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
    div_acc   = {1'b0, rem_n, quo_n};
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qm1_d   = qm1_q;
    opnd_d  = opnd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          qm1_d  = 1'b0;
          qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          if (!op) begin
            acc_d   = {{AW{1'b0}}, a};
            opnd_d  = {{2{b[WIDTH-1]}}, b};
            state_d = S_MULT;
          end else if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            acc_d   = {{AW{1'b0}}, a_mag};
            opnd_d  = {2'b00, b_mag};
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d = booth_acc;
        qm1_d = acc_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = booth_acc[2*WIDTH-1:WIDTH];
          lo_d    = booth_acc[WIDTH-1:0];
          state_d = S_FIN;
        end
      end
      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Min-int / -1 yields magnitude 2^(WIDTH-1) with positive sign, which wraps to min-int.
          lo_d    = qneg_q ? -quo_n : quo_n;
          hi_d    = rneg_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      opnd_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qm1_q   <= qm1_d;
      opnd_q  <= opnd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero and done cycle,
// an independent monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
        check("div_zero", 64'(div_zero), 64'(e.dz));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // lat = number of edges after the start edge until done is visible (0 for divide-by-zero).
  task automatic launch(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    sb.push_back('{hi: ehi, lo: elo, dz: edz, cyc: cyc + 1 + lat});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic finish_op();
    wait_done();
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_one_cycle", 64'(done), 64'(0));
    check("div_zero_low", 64'(div_zero), 64'(0));
  endtask

  task automatic run_op(input logic op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input int lat);
    launch(op_i, a_i, b_i, ehi, elo, edz, lat);
    finish_op();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_div_zero", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));

    // Multiplies
    run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 32);
    run_op(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, 1'b0, 32);

    // Divides
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    run_op(1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 32);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0, 32);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 32);

    // Divide by zero keeps a prior HI=0x11 / LO=0x22 (0x451 / 0x20 = 34 rem 17)
    run_op(1'b1, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0, 32);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 1'b1, 0);

    // Start during a multiply and operand changes are ignored; start at FIN->IDLE also ignored.
    launch(1'b0, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0, 32);
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd77;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("no_second_op", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of a divide
    launch(1'b1, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D, 1'b0, 32);
    repeat (9) @(negedge clk);
    #2;
    sb.delete();
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    check("async_rst_hi", 64'(hi), 64'(0));
    check("async_rst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    #2;
    reset = 1'b0;
    run_op(1'b0, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0, 32);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
